// File: rtl/ws2812b_frame_ctrl.sv
// Pixel buffer plus frame sequencer feeding a WS2812B bit driver.
// Colours are brightness-scaled on load and offered over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for start with a non-zero length
//   LOAD  | read and scale the current pixel into the output register
//   OFFER | drv_valid high, holding data until the driver takes it
//   DRAIN | last pixel taken, waiting for driver to finish the reset gap
module ws2812b_frame_ctrl #(
  parameter int NUM_PIXELS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_we,
  input  logic [3:0]  pix_addr,
  input  logic [23:0] pix_data,
  input  logic [7:0]  bright,
  input  logic [4:0]  len,
  input  logic        start,
  input  logic        cont,
  output logic        busy,
  output logic        done,
  output logic [23:0] drv_data,
  output logic        drv_valid,
  output logic        drv_latch,
  input  logic        drv_ready
);
  localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [4:0] NP = 5'(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, LOAD, OFFER, DRAIN} state_t;
  state_t state, state_nxt;

  logic [23:0]   pix_mem [2**AW];
  logic [1:0]    rst_sync;
  logic [AW-1:0] idx, idx_nxt;
  logic [4:0]    frame_len, frame_len_nxt;
  logic          busy_nxt, done_nxt, latch_nxt;
  logic [23:0]   data_nxt, cur_pix;
  logic          is_last, accept;

  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
  endfunction

  // Reset asserts immediately but start is only honoured once release has synchronised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) pix_mem[i] <= '0;
    end else if (pix_we && ({1'b0, pix_addr} < NP)) begin
      pix_mem[pix_addr[AW-1:0]] <= pix_data;
    end
  end

  assign cur_pix   = pix_mem[idx];
  assign is_last   = (5'(idx) == (frame_len - 5'd1));
  assign accept    = start && (len != 5'd0) && rst_sync[1];
  assign drv_valid = (state == OFFER);

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    frame_len_nxt = frame_len;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    data_nxt      = drv_data;
    latch_nxt     = drv_latch;
    case (state)
      IDLE: begin
        if (accept) begin
          frame_len_nxt = (len > NP) ? NP : len;
          idx_nxt       = '0;
          busy_nxt      = 1'b1;
          state_nxt     = LOAD;
        end
      end
      LOAD: begin
        data_nxt  = {scale8(cur_pix[23:16], bright), scale8(cur_pix[15:8], bright),
                     scale8(cur_pix[7:0], bright)};
        latch_nxt = is_last;
        state_nxt = OFFER;
      end
      OFFER: begin
        if (drv_ready) begin
          if (drv_latch) begin
            latch_nxt = 1'b0;
            state_nxt = DRAIN;
          end else begin
            idx_nxt   = idx + AW'(1);
            state_nxt = LOAD;
          end
        end
      end
      DRAIN: begin
        if (drv_ready) begin
          done_nxt = 1'b1;
          if (cont) begin
            idx_nxt   = '0;
            state_nxt = LOAD;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      frame_len <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drv_data  <= '0;
      drv_latch <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      frame_len <= frame_len_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      drv_data  <= data_nxt;
      drv_latch <= latch_nxt;
    end
  end
endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Bench for ws2812b_frame_ctrl: randomized frames against a behavioural frame model,
// plus directed literal checks for scaling, clamping, backpressure, continuous mode and reset.
module tb_ws2812b_frame_ctrl;
  localparam int NP = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pix_we = 1'b0, start = 1'b0, cont = 1'b0, drv_ready = 1'b0;
  logic [3:0]  pix_addr = '0;
  logic [23:0] pix_data = '0;
  logic [7:0]  bright = '0;
  logic [4:0]  len = '0;
  logic        busy, done, drv_valid, drv_latch;
  logic [23:0] drv_data;

  int total = 0, bad = 0;

  ws2812b_frame_ctrl #(.NUM_PIXELS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .bright(bright), .len(len), .start(start), .cont(cont), .busy(busy), .done(done),
    .drv_data(drv_data), .drv_valid(drv_valid), .drv_latch(drv_latch), .drv_ready(drv_ready)
  );

  always #5 clk = ~clk;

  // model state: expected outputs after the next edge
  logic [23:0] shadow [16];
  int          m_len, m_k, rst_cnt, dut_dones, rmode, hold;
  bit          m_busy, m_done, m_valid, m_gap, m_drain, m_latch, hs_next;
  logic [23:0] m_data;
  logic [23:0] log_data [$];
  bit          log_latch [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] scaled(input logic [23:0] c, input logic [7:0] b);
    int g, r, bl;
    g  = (int'(c[23:16]) * (int'(b) + 1)) / 256;
    r  = (int'(c[15:8])  * (int'(b) + 1)) / 256;
    bl = (int'(c[7:0])   * (int'(b) + 1)) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  function automatic logic [24:0] log_at(input int i);
    if (i < log_data.size()) return {log_latch[i], log_data[i]};
    return 'x;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", drv_valid, 0);
        chk("rst_latch", drv_latch, 0);
        chk("rst_data", drv_data, 0);
        m_busy = 0; m_done = 0; m_valid = 0; m_gap = 0; m_drain = 0; m_k = 0; m_len = 0;
        rst_cnt = 0; hs_next = 0;
        foreach (shadow[i]) shadow[i] = '0;
      end else begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("valid", drv_valid, m_valid);
        if (drv_valid && m_valid) begin
          chk("data", drv_data, m_data);
          chk("latch", drv_latch, m_latch);
        end
        if (done === 1'b1) dut_dones++;
        hs_next = drv_valid && drv_ready;
        m_done = 0;
        if (m_valid && drv_ready) begin
          log_data.push_back(drv_data);
          log_latch.push_back(drv_latch);
          m_valid = 0;
          if (m_k == m_len - 1) m_drain = 1;
          else begin m_k++; m_gap = 1; end
        end else if (m_gap) begin
          m_gap = 0; m_valid = 1;
          m_data = scaled(shadow[m_k], bright);
          m_latch = (m_k == m_len - 1);
        end else if (m_drain) begin
          if (drv_ready) begin
            m_drain = 0; m_done = 1;
            if (cont) begin m_k = 0; m_gap = 1; end
            else m_busy = 0;
          end
        end else if (!m_busy && start && len != 0 && rst_cnt >= 2) begin
          m_len = (int'(len) > NP) ? NP : int'(len);
          m_k = 0; m_busy = 1; m_gap = 1;
        end
        if (pix_we && int'(pix_addr) < NP) shadow[pix_addr] = pix_data;
        if (rst_cnt < 2) rst_cnt++;
      end
    end
  end

  // driver ready model: 0 always ready, 1 drop after handshake for 90 cycles, 2 random, 3 manual
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: drv_ready = 1'b1;
        1: begin
          if (hs_next) begin drv_ready = 1'b0; hold = 90; end
          else if (hold > 0) begin hold--; if (hold == 0) drv_ready = 1'b1; end
        end
        2: drv_ready = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_pix(input int a, input logic [23:0] d);
    pix_we = 1'b1; pix_addr = 4'(a); pix_data = d;
    step();
    pix_we = 1'b0;
  endtask

  task automatic start_frame(input int l);
    len = 5'(l); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    chk("idle_timeout", busy, 0);
    step();
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!drv_valid && n < 10) begin step(); n++; end
    chk(nm, drv_valid, 1);
  endtask

  initial begin
    int h0, d0, l, e, nlat;
    bit dropped;
    logic [23:0] v [5];
    logic [23:0] newv;
    rmode = 3; hold = 0; dut_dones = 0;

    repeat (8) begin
      step();
      pix_we = 1'($urandom); pix_addr = 4'($urandom); pix_data = 24'($urandom);
      start = 1'($urandom); len = 5'($urandom); bright = 8'($urandom);
      cont = 1'($urandom); drv_ready = 1'($urandom);
    end
    pix_we = 0; start = 0; cont = 0; len = 0; drv_ready = 0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    start_frame(0);
    repeat (5) step();
    chk("len0_busy", busy, 0);
    chk("len0_done", dut_dones, 0);

    // basic two-pixel frame with slow driver
    rmode = 1; drv_ready = 1'b1;
    bright = 8'hFF;
    write_pix(0, 24'hFF8040);
    write_pix(1, 24'h000001);
    h0 = log_data.size(); d0 = dut_dones;
    start_frame(2);
    wait_idle(2000);
    chk("t1_count", log_data.size() - h0, 2);
    chk("t1_px0", log_at(h0), {1'b0, 24'hFF8040});
    chk("t1_px1", log_at(h0 + 1), {1'b1, 24'h000001});
    chk("t1_done", dut_dones - d0, 1);

    // scaling
    rmode = 0;
    bright = 8'h7F;
    h0 = log_data.size();
    start_frame(1);
    wait_idle(100);
    chk("t2_half", log_at(h0), {1'b1, 24'h7F4020});
    bright = 8'h00;
    h0 = log_data.size();
    start_frame(1);
    wait_idle(100);
    chk("t2_zero", log_at(h0), {1'b1, 24'h000000});

    // clamp to buffer depth, second start ignored mid-frame
    rmode = 2;
    for (int i = 0; i < NP; i++) write_pix(i, 24'($urandom));
    bright = 8'($urandom);
    h0 = log_data.size();
    start_frame(12);
    repeat (4) step();
    start_frame(5);
    wait_idle(2000);
    chk("t3_count", log_data.size() - h0, 8);
    nlat = 0;
    for (int i = 0; i < 8; i++) nlat += int'(log_at(h0 + i) >> 24);
    chk("t3_latch_num", nlat, 1);
    chk("t3_latch_last", log_at(h0 + 7) >> 24, 1);

    // backpressure and write during frame
    rmode = 3; drv_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin v[i] = 24'($urandom); write_pix(i, v[i]); end
    bright = 8'hFF;
    newv = v[3] ^ 24'h5A5A5A;
    h0 = log_data.size();
    start_frame(5);
    wait_valid("t4_valid_up");
    write_pix(3, newv);
    repeat (49) step();
    chk("t4_hold_data", drv_data, v[0]);
    chk("t4_hold_latch", drv_latch, 0);
    rmode = 0;
    wait_idle(500);
    chk("t4_count", log_data.size() - h0, 5);
    chk("t4_px3_new", log_at(h0 + 3), {1'b0, newv});
    chk("t4_px4", log_at(h0 + 4), {1'b1, v[4]});

    // continuous mode
    rmode = 2; bright = 8'($urandom); cont = 1'b1;
    h0 = log_data.size(); d0 = dut_dones; dropped = 0;
    start_frame(3);
    for (int n = 0; n < 3000 && (dut_dones - d0) < 2; n++) begin
      if (!busy) dropped = 1;
      step();
    end
    chk("t5_two_dones", dut_dones - d0, 2);
    chk("t5_busy_held", dropped, 0);
    cont = 1'b0;
    wait_idle(3000);
    chk("t5_dones_total", dut_dones - d0, 3);
    chk("t5_hs_total", log_data.size() - h0, 9);

    // randomized frames
    for (int it = 0; it < 25; it++) begin
      rmode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      bright = 8'($urandom);
      repeat ($urandom_range(0, 4)) write_pix($urandom_range(0, 15), 24'($urandom));
      l = $urandom_range(0, 20);
      e = (l == 0) ? 0 : ((l > NP) ? NP : l);
      h0 = log_data.size();
      start_frame(l);
      wait_idle(2000);
      chk("rnd_hs_count", log_data.size() - h0, e);
    end

    // asynchronous reset in OFFER, buffer cleared afterwards
    rmode = 3; drv_ready = 1'b0;
    write_pix(1, 24'h123456);
    start_frame(2);
    wait_valid("t6_valid_up");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", drv_valid, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_data_async", drv_data, 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    rmode = 0; bright = 8'hFF;
    h0 = log_data.size();
    start_frame(2);
    wait_idle(200);
    chk("t6_buf_cleared", log_at(h0 + 1), {1'b1, 24'h000000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
